// File: rtl/hbconsole_mux.sv
// hbconsole_mux: merges console/hexbus 7-bit tx streams into one tagged UART byte stream and splits rx bytes back.
// Ports: i_clk/i_rst clock and async active-high reset; i_con_*/o_con_busy console tx source;
// i_hb_*/o_hb_busy hexbus tx source; o_tx_stb/o_tx_data/i_tx_busy UART tx sink;
// i_rx_stb/i_rx_data UART rx byte; o_hb_stb/o_hb_data and o_con_stb/o_con_data split rx streams.
// Byte bit 7 tags the channel: 1 = hexbus, 0 = console.
module hbconsole_mux #(
  parameter int LGTIMEOUT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_con_stb,
  input  logic [6:0] i_con_data,
  output logic       o_con_busy,
  input  logic       i_hb_stb,
  input  logic [6:0] i_hb_data,
  output logic       o_hb_busy,
  output logic       o_tx_stb,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  input  logic       i_rx_stb,
  input  logic [7:0] i_rx_data,
  output logic       o_hb_stb,
  output logic [6:0] o_hb_data,
  output logic       o_con_stb,
  output logic [6:0] o_con_data
);
  typedef enum logic {IDLE, HB_LOCK} state_t;
  state_t                 r_state;
  logic                   r_last_hb;
  logic [LGTIMEOUT-1:0]   r_idle;
  logic                   w_ready, w_sel_hb, w_sel_con, w_hb_acc, w_con_acc;
  always_comb begin
    w_ready    = !o_tx_stb || !i_tx_busy;
    // on a tie the source not served last wins; the lock excludes the console entirely
    w_sel_hb   = (r_state == HB_LOCK) ? i_hb_stb : i_hb_stb && (!i_con_stb || !r_last_hb);
    w_sel_con  = (r_state == IDLE) && i_con_stb && (!i_hb_stb || r_last_hb);
    w_hb_acc   = w_sel_hb && w_ready;
    w_con_acc  = w_sel_con && w_ready;
    o_hb_busy  = !w_hb_acc;
    o_con_busy = !w_con_acc;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_last_hb <= 1'b0;
      r_idle    <= '0;
      o_tx_stb  <= 1'b0;
      o_tx_data <= 8'h00;
    end else begin
      if (w_ready) begin
        o_tx_stb  <= w_hb_acc || w_con_acc;
        o_tx_data <= w_hb_acc ? {1'b1, i_hb_data} : w_con_acc ? {1'b0, i_con_data} : o_tx_data;
        r_last_hb <= w_hb_acc ? 1'b1 : w_con_acc ? 1'b0 : r_last_hb;
      end
      // a newline ends the hexbus word; a run of 2^LGTIMEOUT accept-free cycles abandons it
      if (w_hb_acc) begin
        r_state <= (i_hb_data == 7'h0a) ? IDLE : HB_LOCK;
        r_idle  <= '0;
      end else if (r_state == HB_LOCK) begin
        r_state <= (&r_idle) ? IDLE : HB_LOCK;
        r_idle  <= r_idle + 1'b1;
      end else begin
        r_idle  <= '0;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hb_stb   <= 1'b0;
      o_hb_data  <= 7'h00;
      o_con_stb  <= 1'b0;
      o_con_data <= 7'h00;
    end else begin
      o_hb_stb   <= i_rx_stb && i_rx_data[7];
      o_con_stb  <= i_rx_stb && !i_rx_data[7];
      o_hb_data  <= i_rx_stb ? i_rx_data[6:0] : o_hb_data;
      o_con_data <= i_rx_stb ? i_rx_data[6:0] : o_con_data;
    end
  end
endmodule

// File: tb/tb_hbconsole_mux.sv
// tb_hbconsole_mux: directed plan scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_hbconsole_mux;
  localparam int LG = 3;
  logic       i_clk = 0, i_rst = 0;
  logic       i_con_stb = 0, i_hb_stb = 0, i_tx_busy = 0, i_rx_stb = 0;
  logic [6:0] i_con_data = 0, i_hb_data = 0;
  logic [7:0] i_rx_data = 0;
  logic       o_con_busy, o_hb_busy, o_tx_stb, o_hb_stb, o_con_stb;
  logic [7:0] o_tx_data;
  logic [6:0] o_hb_data, o_con_data;

  hbconsole_mux #(.LGTIMEOUT(LG)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_con_stb(i_con_stb), .i_con_data(i_con_data), .o_con_busy(o_con_busy),
    .i_hb_stb(i_hb_stb), .i_hb_data(i_hb_data), .o_hb_busy(o_hb_busy),
    .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
    .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data),
    .o_hb_stb(o_hb_stb), .o_hb_data(o_hb_data),
    .o_con_stb(o_con_stb), .o_con_data(o_con_data)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_bad = 0;
  bit         m_lock, m_last_hb;
  int         m_gap;
  logic       m_tx_stb, m_hb_stb, m_con_stb;
  logic [7:0] m_tx_data;
  logic [6:0] m_hb_data, m_con_data;
  logic       s_con_busy, s_hb_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_lock = 0; m_last_hb = 0; m_gap = 0;
    m_tx_stb = 0; m_tx_data = 0;
    m_hb_stb = 0; m_hb_data = 0; m_con_stb = 0; m_con_data = 0;
  endfunction

  task automatic check_outputs();
    chk("tx_stb", o_tx_stb, m_tx_stb);
    chk("tx_data", o_tx_data, m_tx_data);
    chk("rx_hb_stb", o_hb_stb, m_hb_stb);
    chk("rx_hb_data", o_hb_data, m_hb_data);
    chk("rx_con_stb", o_con_stb, m_con_stb);
    chk("rx_con_data", o_con_data, m_con_data);
  endtask

  task automatic step(input logic hs, input logic [6:0] hd, input logic cs, input logic [6:0] cd,
                      input logic tb, input logic rs, input logic [7:0] rd);
    logic rdy, ph, pc, hacc, cacc;
    @(negedge i_clk);
    check_outputs();
    i_hb_stb = hs; i_hb_data = hd; i_con_stb = cs; i_con_data = cd;
    i_tx_busy = tb; i_rx_stb = rs; i_rx_data = rd;
    #1;
    rdy = !m_tx_stb || !tb;
    if (m_lock) begin ph = hs; pc = 0; end
    else if (hs && cs) begin ph = !m_last_hb; pc = m_last_hb; end
    else begin ph = hs; pc = cs; end
    hacc = ph && rdy;
    cacc = pc && rdy;
    chk("hb_busy", o_hb_busy, !hacc);
    chk("con_busy", o_con_busy, !cacc);
    s_hb_busy = o_hb_busy;
    s_con_busy = o_con_busy;
    @(posedge i_clk);
    if (rdy) m_tx_stb = hacc || cacc;
    if (hacc) begin m_tx_data = {1'b1, hd}; m_last_hb = 1; end
    if (cacc) begin m_tx_data = {1'b0, cd}; m_last_hb = 0; end
    if (hacc) begin
      m_lock = (hd != 7'h0a);
      m_gap = 0;
    end else if (m_lock) begin
      m_gap++;
      if (m_gap == (1 << LG)) begin m_lock = 0; m_gap = 0; end
    end
    m_hb_stb = rs && rd[7];
    m_con_stb = rs && !rd[7];
    if (rs) begin m_hb_data = rd[6:0]; m_con_data = rd[6:0]; end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_hb_stb = 0; i_con_stb = 0; i_tx_busy = 0; i_rx_stb = 0;
    #2 i_rst = 1;
    #1;
    chk("rst_tx_stb", o_tx_stb, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_hb_stb", o_hb_stb, 0);
    chk("rst_hb_data", o_hb_data, 0);
    chk("rst_con_stb", o_con_stb, 0);
    chk("rst_con_data", o_con_data, 0);
    model_reset();
    @(negedge i_clk);
    i_rst = 0;
  endtask

  initial begin
    logic [6:0] hseq [3];
    logic [7:0] rxs [3];
    int gap;
    bit found;
    int p_hb, p_con, p_tb, p_rx;
    hseq = '{7'h52, 7'h31, 7'h0a};
    rxs = '{8'hd2, 8'h41, 8'h8a};
    do_reset();
    step(1, 7'h0a, 0, 0, 0, 0, 0);
    #1 chk("pre_rst_tx_stb", o_tx_stb, 1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 7'h0a, 1, 7'h41, 0, 0, 0);
      #1 chk("tie_seq", o_tx_data, (i % 2) ? 8'h41 : 8'h8a);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, hseq[i], 1, 7'h42, 0, 0, 0);
      chk("lock_con_busy", s_con_busy, 1);
      #1 chk("lock_tx", o_tx_data, {1'b1, hseq[i]});
    end
    step(0, 0, 1, 7'h42, 0, 0, 0);
    #1 chk("post_lock_tx", o_tx_data, 8'h42);
    for (int i = 0; i < 5; i++) begin
      step(1, 7'h55, 1, 7'h44, 1, 0, 0);
      chk("bp_hb_busy", s_hb_busy, 1);
      chk("bp_con_busy", s_con_busy, 1);
      #1 chk("bp_hold", o_tx_data, 8'h42);
    end
    step(1, 7'h55, 1, 7'h44, 0, 0, 0);
    #1 chk("bp_release", o_tx_data, 8'hd5);
    step(1, 7'h0a, 0, 0, 0, 0, 0);
    #1 chk("bp_newline", o_tx_data, 8'h8a);
    step(1, 7'h52, 0, 0, 0, 0, 0);
    #1 chk("tmo_start", o_tx_data, 8'hd2);
    gap = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(0, 0, 1, 7'h43, 0, 0, 0);
      if (s_con_busy) gap++;
      else found = 1;
    end
    chk("tmo_found", found, 1);
    chk("tmo_idle_cycles", gap, 8);
    #1 chk("tmo_con_tx", o_tx_data, 8'h43);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1, rxs[i]);
      #1;
      chk("rx_split_hb", o_hb_stb, rxs[i][7]);
      chk("rx_split_con", o_con_stb, !rxs[i][7]);
      chk("rx_split_data", rxs[i][7] ? o_hb_data : o_con_data, rxs[i][6:0]);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    #1 chk("rx_quiet", {o_hb_stb, o_con_stb}, 0);
    for (int s = 0; s < 30; s++) begin
      p_hb = $urandom_range(0, 100);
      p_con = $urandom_range(0, 100);
      p_tb = $urandom_range(0, 80);
      p_rx = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, 399) == 0) do_reset();
        else step($urandom_range(0, 99) < p_hb,
                  ($urandom_range(0, 3) == 0) ? 7'h0a : 7'($urandom),
                  $urandom_range(0, 99) < p_con, 7'($urandom),
                  $urandom_range(0, 99) < p_tb,
                  $urandom_range(0, 99) < p_rx, 8'($urandom));
      end
    end
    @(negedge i_clk);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
